// File: rtl/pc_pkg.sv
// Shared encodings and constants for the program-counter unit and its
// return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_REG = 2'b11
  } pc_src_e;

  localparam int PC_INC = 4;

  // Counter width able to hold 0..depth inclusive.
  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the fetch controller (master) and pc_unit (slave).
// No handshake: inputs are sampled on every rising edge where Stall=0.
interface pc_unit_if
  import pc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = ras_cnt_w(RAS_DEPTH);

  logic             Stall;
  pc_src_e          PCSrc;
  logic             Take;
  logic [15:0]      Imm;
  logic [25:0]      Addr;
  logic [WIDTH-1:0] RegAddr;
  logic             Link;
  logic             Ret;

  logic [WIDTH-1:0] PCout;
  logic [WIDTH-1:0] PCin;
  logic [WIDTH-1:0] PCplus4;
  logic             RasFull;
  logic             RasEmpty;
  logic             AlignErr;
  logic [CW-1:0]    RasCount;

  modport master (
    output Stall, PCSrc, Take, Imm, Addr, RegAddr, Link, Ret,
    input  PCout, PCin, PCplus4, RasFull, RasEmpty, AlignErr, RasCount
  );

  modport slave (
    input  Stall, PCSrc, Take, Imm, Addr, RegAddr, Link, Ret,
    output PCout, PCin, PCplus4, RasFull, RasEmpty, AlignErr, RasCount
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and push+pop together replaces the top in place.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [WIDTH-1:0]               data_i,
  output logic [WIDTH-1:0]               top_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [ras_cnt_w(RAS_DEPTH)-1:0] count_o
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = ras_cnt_w(RAS_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    top_q, top_d, wr_idx;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign top_o   = mem_q[top_q];
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = top_q;
    if (push_i && pop_ok) begin
      wr_en = 1'b1;
    end else if (push_i) begin
      top_d  = top_q + 1'b1;
      wr_idx = top_q + 1'b1;
      wr_en  = 1'b1;
      if (!full_o) count_d = count_q + 1'b1;
    end else if (pop_ok) begin
      top_d   = top_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  // Entry contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/jump/register target selection, alignment
// rejection and a return-address stack for call/return prediction.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic    CLK,
  input  logic    Reset,
  pc_unit_if.slave bus
);
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             align_err_q, align_err_d;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ras_top;
  logic             ras_full, ras_empty;
  logic             link_ok, ret_ok, misaligned, accept;
  logic             ras_push, ras_pop;

  assign pc_plus4 = pc_q + WIDTH'(PC_INC);
  assign br_off   = {{(WIDTH-18){bus.Imm[15]}}, bus.Imm, 2'b00};
  assign link_ok  = bus.Link && (bus.PCSrc == PC_J || bus.PCSrc == PC_REG);
  assign ret_ok   = bus.Ret && (bus.PCSrc == PC_REG);

  always_comb begin
    target = pc_plus4;
    case (bus.PCSrc)
      PC_SEQ: target = pc_plus4;
      PC_BR:  target = bus.Take ? (pc_plus4 + br_off) : pc_plus4;
      PC_J:   target = {pc_plus4[WIDTH-1:28], bus.Addr, 2'b00};
      PC_REG: target = (ret_ok && !ras_empty) ? ras_top : bus.RegAddr;
      default: target = pc_plus4;
    endcase
  end

  // A misaligned or stalled cycle leaves the PC and the stack untouched.
  assign misaligned = (target[1:0] != 2'b00);
  assign accept     = !bus.Stall && !misaligned;
  assign ras_push   = accept && link_ok;
  assign ras_pop    = accept && ret_ok;

  always_comb begin
    pc_d        = accept ? target : pc_q;
    align_err_d = !bus.Stall && misaligned;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      pc_q        <= RESET_VEC;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      align_err_q <= align_err_d;
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (CLK),
    .rst_ni  (Reset),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_plus4),
    .top_o   (ras_top),
    .full_o  (ras_full),
    .empty_o (ras_empty),
    .count_o (bus.RasCount)
  );

  assign bus.PCout    = pc_q;
  assign bus.PCin     = pc_d;
  assign bus.PCplus4  = pc_plus4;
  assign bus.RasFull  = ras_full;
  assign bus.RasEmpty = ras_empty;
  assign bus.AlignErr = align_err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, branch, jump, wrap, return stack,
// stall, misalignment and reset during a pop.
module tb_pc_unit;
  import pc_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pc_unit_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();

  pc_unit #(
    .WIDTH     (32),
    .RESET_VEC (32'h0040_0000),
    .RAS_DEPTH (4)
  ) u_dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Stall   = 1'b0;
    bus.PCSrc   = PC_SEQ;
    bus.Take    = 1'b0;
    bus.Imm     = 16'h0000;
    bus.Addr    = 26'h0;
    bus.RegAddr = 32'h0;
    bus.Link    = 1'b0;
    bus.Ret     = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    idle();
    bus.PCSrc   = PC_REG;
    bus.RegAddr = v;
    step();
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    idle();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (bus.PCout !== 32'h0040_0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.PCout, 32'h0040_0000); end
    checks++; if (bus.RasEmpty !== 1'b1 || bus.RasFull !== 1'b0) begin failures++; $display("FAIL reset_flags got=e%b f%b exp=e1 f0", bus.RasEmpty, bus.RasFull); end
    checks++; if (bus.AlignErr !== 1'b0 || bus.RasCount !== 3'd0) begin failures++; $display("FAIL reset_err_cnt got=a%b c%0d exp=a0 c0", bus.AlignErr, bus.RasCount); end
    rst_n = 1'b1;
    exp_pc = 32'h0040_0000;
    for (int i = 0; i < 3; i++) begin
      exp_pc = exp_pc + 32'd4;
      step();
      checks++; if (bus.PCout !== exp_pc) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.PCout, exp_pc); end
    end
  endtask

  task automatic test_branch();
    set_pc(32'h0000_0100);
    bus.PCSrc = PC_BR; bus.Imm = 16'hFFFC; bus.Take = 1'b1;
    #1;
    checks++; if (bus.PCin !== 32'h0000_00F4) begin failures++; $display("FAIL br_taken_pcin got=%h exp=%h", bus.PCin, 32'h0000_00F4); end
    step();
    checks++; if (bus.PCout !== 32'h0000_00F4) begin failures++; $display("FAIL br_taken_pc got=%h exp=%h", bus.PCout, 32'h0000_00F4); end
    set_pc(32'h0000_0100);
    bus.PCSrc = PC_BR; bus.Imm = 16'hFFFC; bus.Take = 1'b0;
    step();
    checks++; if (bus.PCout !== 32'h0000_0104) begin failures++; $display("FAIL br_not_taken_pc got=%h exp=%h", bus.PCout, 32'h0000_0104); end
    set_pc(32'h0000_0100);
    bus.PCSrc = PC_BR; bus.Imm = 16'h0010; bus.Take = 1'b1;
    step();
    checks++; if (bus.PCout !== 32'h0000_0144) begin failures++; $display("FAIL br_fwd_pc got=%h exp=%h", bus.PCout, 32'h0000_0144); end
    idle();
  endtask

  task automatic test_jump_wrap();
    set_pc(32'h0040_0010);
    bus.PCSrc = PC_J; bus.Addr = 26'h010_0000;
    step();
    checks++; if (bus.PCout !== 32'h0040_0000) begin failures++; $display("FAIL jump_pc got=%h exp=%h", bus.PCout, 32'h0040_0000); end
    set_pc(32'hF000_0010);
    bus.PCSrc = PC_J; bus.Addr = 26'h000_0040;
    step();
    checks++; if (bus.PCout !== 32'hF000_0100) begin failures++; $display("FAIL jump_upper_pc got=%h exp=%h", bus.PCout, 32'hF000_0100); end
    set_pc(32'hFFFF_FFFC);
    checks++; if (bus.PCplus4 !== 32'h0000_0000) begin failures++; $display("FAIL wrap_plus4 got=%h exp=%h", bus.PCplus4, 32'h0); end
    step();
    checks++; if (bus.PCout !== 32'h0000_0000) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", bus.PCout, 32'h0); end
  endtask

  task automatic test_ras();
    logic [31:0] exp_pops [4];
    logic [2:0]  exp_cnt;
    exp_pops[0] = 32'h54; exp_pops[1] = 32'h44; exp_pops[2] = 32'h34; exp_pops[3] = 32'h24;
    for (int i = 1; i <= 5; i++) begin
      set_pc(32'(i * 16));
      bus.PCSrc = PC_J; bus.Link = 1'b1; bus.Addr = 26'h100;
      step();
      exp_cnt = (i > 4) ? 3'd4 : 3'(i);
      checks++; if (bus.PCout !== 32'h400 || bus.RasCount !== exp_cnt) begin failures++; $display("FAIL jal_push[%0d] got=pc%h c%0d exp=pc%h c%0d", i, bus.PCout, bus.RasCount, 32'h400, exp_cnt); end
    end
    checks++; if (bus.RasFull !== 1'b1 || bus.RasEmpty !== 1'b0) begin failures++; $display("FAIL ras_full got=f%b e%b exp=f1 e0", bus.RasFull, bus.RasEmpty); end
    idle();
    bus.PCSrc = PC_REG; bus.Ret = 1'b1; bus.RegAddr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.PCout !== exp_pops[i] || bus.RasCount !== 3'(3 - i)) begin failures++; $display("FAIL ret_pop[%0d] got=pc%h c%0d exp=pc%h c%0d", i, bus.PCout, bus.RasCount, exp_pops[i], 3 - i); end
    end
    checks++; if (bus.RasEmpty !== 1'b1 || bus.RasFull !== 1'b0) begin failures++; $display("FAIL ras_empty got=e%b f%b exp=e1 f0", bus.RasEmpty, bus.RasFull); end
    bus.RegAddr = 32'h200;
    step();
    checks++; if (bus.PCout !== 32'h200 || bus.RasCount !== 3'd0) begin failures++; $display("FAIL ret_empty got=pc%h c%0d exp=pc%h c0", bus.PCout, bus.RasCount, 32'h200); end
  endtask

  task automatic test_link_ret();
    idle();
    bus.PCSrc = PC_J; bus.Link = 1'b1; bus.Addr = 26'h100;
    step();
    idle();
    bus.PCSrc = PC_REG; bus.Link = 1'b1; bus.Ret = 1'b1; bus.RegAddr = 32'h300;
    #1;
    checks++; if (bus.PCin !== 32'h204) begin failures++; $display("FAIL swap_pcin got=%h exp=%h", bus.PCin, 32'h204); end
    step();
    checks++; if (bus.PCout !== 32'h204 || bus.RasCount !== 3'd1) begin failures++; $display("FAIL swap_pc got=pc%h c%0d exp=pc%h c1", bus.PCout, bus.RasCount, 32'h204); end
    bus.Link = 1'b0;
    step();
    checks++; if (bus.PCout !== 32'h404 || bus.RasCount !== 3'd0) begin failures++; $display("FAIL swap_top got=pc%h c%0d exp=pc%h c0", bus.PCout, bus.RasCount, 32'h404); end
    bus.Link = 1'b1; bus.RegAddr = 32'h500;
    step();
    checks++; if (bus.PCout !== 32'h500 || bus.RasCount !== 3'd1) begin failures++; $display("FAIL linkret_empty got=pc%h c%0d exp=pc%h c1", bus.PCout, bus.RasCount, 32'h500); end
    idle();
  endtask

  task automatic test_stall();
    idle();
    bus.Stall = 1'b1; bus.PCSrc = PC_J; bus.Link = 1'b1; bus.Addr = 26'h100;
    #1;
    checks++; if (bus.PCin !== 32'h500) begin failures++; $display("FAIL stall_pcin got=%h exp=%h", bus.PCin, 32'h500); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.PCout !== 32'h500 || bus.RasCount !== 3'd1 || bus.RasEmpty !== 1'b0 || bus.RasFull !== 1'b0 || bus.AlignErr !== 1'b0) begin failures++; $display("FAIL stall_hold[%0d] got=pc%h c%0d e%b f%b a%b exp=pc%h c1 e0 f0 a0", i, bus.PCout, bus.RasCount, bus.RasEmpty, bus.RasFull, bus.AlignErr, 32'h500); end
    end
    idle();
  endtask

  task automatic test_align();
    idle();
    bus.PCSrc = PC_REG; bus.RegAddr = 32'h102; bus.Link = 1'b1;
    #1;
    checks++; if (bus.PCin !== 32'h500) begin failures++; $display("FAIL align_pcin got=%h exp=%h", bus.PCin, 32'h500); end
    step();
    checks++; if (bus.PCout !== 32'h500 || bus.AlignErr !== 1'b1 || bus.RasCount !== 3'd1) begin failures++; $display("FAIL align_hold got=pc%h a%b c%0d exp=pc%h a1 c1", bus.PCout, bus.AlignErr, bus.RasCount, 32'h500); end
    idle();
    step();
    checks++; if (bus.PCout !== 32'h504 || bus.AlignErr !== 1'b0) begin failures++; $display("FAIL align_pulse got=pc%h a%b exp=pc%h a0", bus.PCout, bus.AlignErr, 32'h504); end
    bus.PCSrc = PC_REG; bus.Ret = 1'b1; bus.RegAddr = 32'h300;
    step();
    checks++; if (bus.PCout !== 32'h408 || bus.RasCount !== 3'd0) begin failures++; $display("FAIL align_ras_intact got=pc%h c%0d exp=pc%h c0", bus.PCout, bus.RasCount, 32'h408); end
    idle();
  endtask

  task automatic test_reset_mid_pop();
    idle();
    bus.PCSrc = PC_J; bus.Link = 1'b1; bus.Addr = 26'h100;
    step();
    checks++; if (bus.RasCount !== 3'd1) begin failures++; $display("FAIL pre_reset_push got=c%0d exp=c1", bus.RasCount); end
    idle();
    bus.PCSrc = PC_REG; bus.Ret = 1'b1; bus.Stall = 1'b1;
    rst_n = 1'b0;
    step();
    checks++; if (bus.PCout !== 32'h0040_0000 || bus.RasCount !== 3'd0 || bus.RasEmpty !== 1'b1 || bus.RasFull !== 1'b0 || bus.AlignErr !== 1'b0) begin failures++; $display("FAIL reset_mid_pop got=pc%h c%0d e%b f%b a%b exp=pc%h c0 e1 f0 a0", bus.PCout, bus.RasCount, bus.RasEmpty, bus.RasFull, bus.AlignErr, 32'h0040_0000); end
    idle();
    rst_n = 1'b1;
    step();
    checks++; if (bus.PCout !== 32'h0040_0004) begin failures++; $display("FAIL post_reset_seq got=%h exp=%h", bus.PCout, 32'h0040_0004); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();
    test_reset();
    test_branch();
    test_jump_wrap();
    test_ras();
    test_link_ret();
    test_stall();
    test_align();
    test_reset_mid_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
